// File: rtl/clock_time_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_time_ctrl
// Purpose  : HH:MM:SS time-keeping with RUN / set-hour / set-minute modes,
//            BCD digit output and per-digit blink mask for the display.
// Revision : 1.0 - initial release
// ============================================================================
module clock_time_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_set,
    input  logic        key_dec,
    input  logic        key_inc,
    output logic [15:0] time_bcd,
    output logic [3:0]  blank,
    output logic [1:0]  mode,
    output logic        sec_pulse
);

    localparam int c_TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
    localparam logic [7:0] c_MAX_HOUR = 8'h23;
    localparam logic [7:0] c_MAX_MS   = 8'h59;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_key_q;
    logic [2:0]             r_key_qq;
    logic [7:0]             r_hour;
    logic [7:0]             r_min;
    logic [7:0]             r_sec;
    logic [c_TICK_W-1:0]    r_presc;
    logic [c_BLINK_W-1:0]   r_blink_cnt;
    logic                   r_phase;

    logic [2:0]             w_press;
    logic                   w_adj_en;
    logic                   w_adj_inc;
    logic                   w_adj_dec;
    logic                   w_tick;
    state_t                 w_next_state;
    logic                   w_next_phase;
    logic [c_BLINK_W-1:0]   w_next_blink_cnt;
    logic [3:0]             w_next_blank;

    // Any code that is not legal BCD or exceeds the field limit restarts at 00.
    function automatic logic bcd_bad(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > lim);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (bcd_bad(v, lim) || (v == lim))
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
        if (bcd_bad(v, lim))
            return 8'h00;
        else if (v == 8'h00)
            return lim;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Key bit order: {set, dec, inc}; press fires once per 1->0 transition.
    assign w_press   = r_key_qq & ~r_key_q;
    assign w_adj_en  = (r_state != ST_RUN) && !w_press[2] && (w_press[1] ^ w_press[0]);
    assign w_adj_inc = w_adj_en & w_press[0];
    assign w_adj_dec = w_adj_en & w_press[1];
    assign w_tick    = (r_state == ST_RUN) && (r_presc == c_TICK_LAST);

    always_comb begin
        w_next_state = r_state;
        if (w_press[2]) begin
            case (r_state)
                ST_RUN:     w_next_state = ST_SET_HR;
                ST_SET_HR:  w_next_state = ST_SET_MIN;
                default:    w_next_state = ST_RUN;
            endcase
        end
    end

    // Mode changes and accepted edits restart the blink so edited digits show at once.
    always_comb begin
        w_next_phase     = r_phase;
        w_next_blink_cnt = r_blink_cnt + c_BLINK_W'(1);
        if (w_press[2] || w_adj_en) begin
            w_next_phase     = 1'b0;
            w_next_blink_cnt = '0;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            w_next_phase     = ~r_phase;
            w_next_blink_cnt = '0;
        end
    end

    always_comb begin
        w_next_blank = 4'b0000;
        if (w_next_phase) begin
            if (w_next_state == ST_SET_HR)
                w_next_blank = 4'b1100;
            else if (w_next_state == ST_SET_MIN)
                w_next_blank = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_key_q     <= 3'b111;
            r_key_qq    <= 3'b111;
            r_hour      <= 8'h00;
            r_min       <= 8'h00;
            r_sec       <= 8'h00;
            r_presc     <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            blank       <= 4'b0000;
            sec_pulse   <= 1'b0;
        end else begin
            r_key_q     <= {key_set, key_dec, key_inc};
            r_key_qq    <= r_key_q;
            r_state     <= w_next_state;
            r_blink_cnt <= w_next_blink_cnt;
            r_phase     <= w_next_phase;
            blank       <= w_next_blank;
            sec_pulse   <= w_tick;

            if (r_state == ST_RUN) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_sec   <= bcd_inc(r_sec, c_MAX_MS);
                    if (r_sec == c_MAX_MS) begin
                        r_min <= bcd_inc(r_min, c_MAX_MS);
                        if (r_min == c_MAX_MS)
                            r_hour <= bcd_inc(r_hour, c_MAX_HOUR);
                    end
                end else begin
                    r_presc <= r_presc + c_TICK_W'(1);
                end
            end else begin
                // Setting freezes seconds at 0 so RUN resumes on a clean minute.
                r_presc <= '0;
                r_sec   <= 8'h00;
                if (r_state == ST_SET_HR) begin
                    if (w_adj_inc)      r_hour <= bcd_inc(r_hour, c_MAX_HOUR);
                    else if (w_adj_dec) r_hour <= bcd_dec(r_hour, c_MAX_HOUR);
                end else begin
                    if (w_adj_inc)      r_min <= bcd_inc(r_min, c_MAX_MS);
                    else if (w_adj_dec) r_min <= bcd_dec(r_min, c_MAX_MS);
                end
            end
        end
    end

    assign time_bcd = {r_hour, r_min};
    assign mode     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_time_ctrl
// Purpose  : Directed stimulus with cycle-stamped expectations in a scoreboard
//            queue; a monitor samples outputs on negedges and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_time_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_set = 1'b1;
    logic        key_dec = 1'b1;
    logic        key_inc = 1'b1;
    logic [15:0] time_bcd;
    logic [3:0]  blank;
    logic [1:0]  mode;
    logic        sec_pulse;

    clock_time_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_set   (key_set),
        .key_dec   (key_dec),
        .key_inc   (key_inc),
        .time_bcd  (time_bcd),
        .blank     (blank),
        .mode      (mode),
        .sec_pulse (sec_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] t;
        logic [1:0]  m;
        logic [3:0]  b;
        logic        sp;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    logic flush   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: cyc equals the number of posedges seen so far at each negedge.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && (flush || q[0].cyc <= cyc)) begin
            e = q.pop_front();
            n_check++;
            if (flush || e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (time_bcd !== e.t || mode !== e.m || blank !== e.b || sec_pulse !== e.sp) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got time=%h mode=%b blank=%b sp=%b, expected time=%h mode=%b blank=%b sp=%b",
                         e.name, cyc, time_bcd, mode, blank, sec_pulse, e.t, e.m, e.b, e.sp);
            end
        end
    end

    task automatic expect_at(input int c, input string nm, input logic [15:0] t,
                             input logic [1:0] m, input logic [3:0] b, input logic sp);
        exp_t e;
        e.cyc = c; e.name = nm; e.t = t; e.m = m; e.b = b; e.sp = sp;
        q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // k = {set, dec, inc}; drives keys low for one cycle. Result visible 2 cycles later.
    task automatic press(input logic [2:0] k);
        {key_set, key_dec, key_inc} = ~k;
        @(negedge clk);
        {key_set, key_dec, key_inc} = 3'b111;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and tick: TICK_DIV=4, first pulse after the 4th edge post-release.
        goto(1);
        expect_at(2,  "reset_state", 16'h0000, 2'b00, 4'b0000, 1'b0);
        goto(2);
        rst = 1'b0;
        expect_at(3,  "after_release", 16'h0000, 2'b00, 4'b0000, 1'b0);
        expect_at(5,  "no_early_pulse", 16'h0000, 2'b00, 4'b0000, 1'b0);
        expect_at(6,  "first_pulse", 16'h0000, 2'b00, 4'b0000, 1'b1);
        expect_at(7,  "pulse_one_cycle", 16'h0000, 2'b00, 4'b0000, 1'b0);
        expect_at(10, "second_pulse", 16'h0000, 2'b00, 4'b0000, 1'b1);

        // Set 23:59 via decrements, then roll over after 60 seconds.
        goto(11); expect_at(13, "enter_set_hr", 16'h0000, 2'b01, 4'b0000, 1'b0); press(3'b100);
        goto(13); expect_at(15, "hour_dec_wrap", 16'h2300, 2'b01, 4'b0000, 1'b0); press(3'b010);
        goto(15); expect_at(17, "enter_set_min", 16'h2300, 2'b10, 4'b0000, 1'b0); press(3'b100);
        goto(17); expect_at(19, "min_dec_wrap", 16'h2359, 2'b10, 4'b0000, 1'b0); press(3'b010);
        goto(19);
        expect_at(21,  "back_to_run", 16'h2359, 2'b00, 4'b0000, 1'b0);
        expect_at(24,  "run_no_pulse", 16'h2359, 2'b00, 4'b0000, 1'b0);
        expect_at(25,  "run_first_sec", 16'h2359, 2'b00, 4'b0000, 1'b1);
        expect_at(260, "before_rollover", 16'h2359, 2'b00, 4'b0000, 1'b0);
        expect_at(261, "rollover_60th", 16'h0000, 2'b00, 4'b0000, 1'b1);
        expect_at(265, "after_rollover", 16'h0000, 2'b00, 4'b0000, 1'b1);
        press(3'b100);

        // Blink in SET_HR with BLINK_DIV=3.
        goto(266);
        expect_at(268, "set_hr_blank0", 16'h0000, 2'b01, 4'b0000, 1'b0);
        expect_at(270, "blink_lo_end", 16'h0000, 2'b01, 4'b0000, 1'b0);
        expect_at(271, "blink_hi", 16'h0000, 2'b01, 4'b1100, 1'b0);
        expect_at(273, "blink_hi_end", 16'h0000, 2'b01, 4'b1100, 1'b0);
        expect_at(274, "blink_lo2", 16'h0000, 2'b01, 4'b0000, 1'b0);
        expect_at(277, "blink_hi2", 16'h0000, 2'b01, 4'b1100, 1'b0);
        press(3'b100);

        // Hold inc for 20 cycles: exactly one increment, blink restarted.
        goto(278);
        expect_at(280, "hold_inc_once", 16'h0100, 2'b01, 4'b0000, 1'b0);
        expect_at(281, "hold_blank_clear", 16'h0100, 2'b01, 4'b0000, 1'b0);
        expect_at(297, "hold_no_repeat", 16'h0100, 2'b01, 4'b1100, 1'b0);
        expect_at(300, "hold_released", 16'h0100, 2'b01, 4'b0000, 1'b0);
        key_inc = 1'b0;
        goto(298);
        key_inc = 1'b1;

        // Hour to 12, then minute wrap without carry.
        goto(300);
        expect_at(322, "hour_to_12", 16'h1200, 2'b01, 4'b0000, 1'b0);
        for (int i = 0; i < 11; i++) begin
            goto(300 + 2 * i); press(3'b001);
        end
        goto(322); expect_at(324, "to_set_min", 16'h1200, 2'b10, 4'b0000, 1'b0); press(3'b100);
        goto(324); expect_at(326, "min_to_59", 16'h1259, 2'b10, 4'b0000, 1'b0); press(3'b010);
        goto(326); expect_at(328, "min_wrap_no_carry", 16'h1200, 2'b10, 4'b0000, 1'b0); press(3'b001);
        goto(328); expect_at(330, "min_dec_back", 16'h1259, 2'b10, 4'b0000, 1'b0); press(3'b010);

        // Simultaneous keys.
        goto(330); expect_at(332, "inc_dec_same", 16'h1259, 2'b10, 4'b0000, 1'b0); press(3'b011);
        goto(332); expect_at(334, "min_to_run", 16'h1259, 2'b00, 4'b0000, 1'b0); press(3'b100);
        goto(334); expect_at(336, "run_to_set_hr", 16'h1259, 2'b01, 4'b0000, 1'b0); press(3'b100);
        goto(336);
        expect_at(338, "set_plus_inc", 16'h1259, 2'b10, 4'b0000, 1'b0);
        expect_at(340, "set_min_blank_lo", 16'h1259, 2'b10, 4'b0000, 1'b0);
        expect_at(341, "set_min_blank_hi", 16'h1259, 2'b10, 4'b0011, 1'b0);
        press(3'b101);

        // Walk to 07:45 in SET_MIN.
        goto(342);
        expect_at(370, "min_to_45", 16'h1245, 2'b10, 4'b0000, 1'b0);
        for (int i = 0; i < 14; i++) begin
            goto(342 + 2 * i); press(3'b010);
        end
        goto(370); expect_at(372, "to_run_1245", 16'h1245, 2'b00, 4'b0000, 1'b0); press(3'b100);
        goto(372); press(3'b100);
        goto(374);
        expect_at(384, "hour_to_07", 16'h0745, 2'b01, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            goto(374 + 2 * i); press(3'b010);
        end
        goto(384); expect_at(386, "set_min_0745", 16'h0745, 2'b10, 4'b0000, 1'b0); press(3'b100);

        // Reset mid-set, then counting resumes from 00:00:00.
        goto(386);
        expect_at(387, "mid_reset", 16'h0000, 2'b00, 4'b0000, 1'b0);
        expect_at(390, "post_reset_no_pulse", 16'h0000, 2'b00, 4'b0000, 1'b0);
        expect_at(391, "post_reset_pulse", 16'h0000, 2'b00, 4'b0000, 1'b1);
        expect_at(626, "post_reset_59s", 16'h0000, 2'b00, 4'b0000, 1'b0);
        expect_at(627, "post_reset_minute", 16'h0001, 2'b00, 4'b0000, 1'b1);
        rst = 1'b1;
        goto(387);
        rst = 1'b0;

        goto(630);
        flush = 1'b1;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Time-keeping and time-setting controller for the DigitalClock design. It sits between the three debounced key outputs and `seg_driver`. It owns the HH:MM:SS counters and the RUN/set-hour/set-minute state machine. It presents BCD digits plus a per-digit blink mask for display.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per second tick (set to a small value in simulation, ≥2).
- `BLINK_DIV`, default 25_000_000: clk cycles per blink half-period (≥2).
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `key_set` in 1: debounced mode key, active-low level (1 = released).
- `key_dec` in 1: debounced subtract-1 key, active-low level.
- `key_inc` in 1: debounced add-1 key, active-low level.
- `time_bcd` out 16: {hour tens, hour ones, minute tens, minute ones}, 4-bit BCD each.
- `blank` out 4: per-digit blank request, bit 3 = hour tens; 1 = digit dark.
- `mode` out 2: 00 RUN, 01 SET_HR, 10 SET_MIN (11 never driven).
- `sec_pulse` out 1: one-cycle pulse per elapsed second in RUN.

## Operation
- **Key press detect:** each key goes through a sync register `k_q` and a history register `k_qq`, both reset to 1. `press = k_qq & ~k_q`. This gives exactly one press per 1→0 transition, and holding a key never repeats.
- **FSM on `key_set` press:** RUN→SET_HR→SET_MIN→RUN.
- **Priority:**
  - A `key_set` press in the same cycle as an inc/dec press advances the mode only; the adjust is dropped.
  - inc and dec pressed in the same cycle: no change.
- **RUN:**
  - Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and `sec_pulse`=1 for that cycle's registered output.
  - Seconds count 0..59. On the 59→0 wrap, minutes +1. On minute 59→00, hours +1. Hour 23→00.
  - inc/dec presses are ignored.
- **SET_HR / SET_MIN:**
  - Prescaler and seconds are held at 0. `sec_pulse`=0.
  - inc/dec adjusts the selected field only. Hour wraps 23↔00; minute wraps 59↔00.
  - There is no carry or borrow between fields in set modes.
- **Leaving SET_MIN→RUN:** seconds=0 and prescaler=0, so the first minute increment comes exactly 60×TICK_DIV cycles later.
- **Arithmetic:** all counters are kept in BCD.
  - Ones digit wraps 9→0 with a tens carry, except at the field limit.
  - Illegal BCD codes are unreachable. Any illegal code found loads 00 for that field.
- **Blink:**
  - `blink_cnt` runs 0..BLINK_DIV-1 continuously. At wrap, `phase` toggles.
  - `phase` and `blink_cnt` clear to 0 on every mode change and every accepted adjust, so the edited digits are visible immediately.
  - `blank` = 4'b1100 in SET_HR and 4'b0011 in SET_MIN, in each case only when phase=1. Otherwise `blank` = 4'b0000. In RUN, `blank` is always 0000.
- **Reset (any cycle, including mid-set):** mode=RUN, time 00:00:00, prescaler=0, blink_cnt=0, phase=0.

## Timing
- All outputs are registered. Reset values:
  - `time_bcd`=16'h0000
  - `blank`=4'b0000
  - `mode`=2'b00
  - `sec_pulse`=0
- **Key latency:** let E0 be the first clk edge at which a key is sampled low.
  - `press` is valid in the cycle after E0.
  - `mode`/`time_bcd`/`blank` update at E1, one edge after E0.
- **sec_pulse:** after reset release, the first `sec_pulse` is high in the cycle following the TICK_DIV-th edge. It then repeats every TICK_DIV cycles.
- **Minute update:** `time_bcd` changes at the same edge that asserts the 60th `sec_pulse`.
- **Reset precedence:** `rst`=1 overrides all other activity at that edge. Outputs show reset values from the following cycle on. Presses whose low level straddles a reset are not counted, because `k_qq`/`k_q` are reset to 1 and only a fresh 1→0 edge seen after reset is detected.

## Test plan
- **Reset and tick:** TICK_DIV=4, rst high 2 cycles then low → `time_bcd`=0000, `mode`=00, `blank`=0000. `sec_pulse` is high one cycle in every 4; the first occurs after 4 edges.
- **Set and rollover:**
  - Press set, dec (hour→23), set, dec (minute→59), set → `mode` returns to 00 and `time_bcd`=16'h2359.
  - After 60 `sec_pulse`s → `time_bcd`=16'h0000.
- **Blink and hold:**
  - In SET_HR with BLINK_DIV=3 → `blank` alternates 0000/1100 every 3 cycles.
  - inc held low 20 cycles → hour +1 exactly once. `blank`=0000 the cycle after the press.
- **Minute wrap without carry:** SET_MIN at 12:59, press inc → `time_bcd`=16'h1200, not 1300. Then press dec → 16'h1259.
- **Simultaneous keys:**
  - inc+dec falling in the same cycle → `time_bcd` unchanged.
  - set+inc in the same cycle from SET_HR → `mode`=10, hour unchanged.
- **Reset mid-operation:** in SET_MIN at 07:45, assert rst one cycle → next cycle `mode`=00, `time_bcd`=0000, `blank`=0000, counting resumes from 00:00:00.
